ifu_fetch: RTL and testbench

Instruction fetch unit: owns the architectural fetch PC, issues in-order word fetches to instruction memory over a valid/ready request channel and a valid-only response channel, and buffers returned words with their PCs. It hands `pc`/`instr` pairs to the IF/ID register, the stage whose output feeds `decode`. On a branch or jump redirect from execute it discards all in-flight and buffered instructions and restarts fetch at the new PC.

---
 rtl/ifu_fetch.sv | 158 +++++++++++++++
 tb/tb_ifu_fetch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit
//
// Owns the architectural fetch PC, issues in-order word fetches to
// instruction memory and buffers the returned words together with their PCs
// until the IF/ID register accepts them. A redirect from execute flushes
// everything buffered, marks every in-flight request as "to be dropped" and
// restarts fetch at the new (word-aligned) PC.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req_valid_o    fetch request valid
//   imem_req_ready_i    memory accepts the request this cycle
//   imem_req_addr_o     word-aligned fetch address (current fetch PC)
//   imem_rsp_valid_i    in-order response valid (no backpressure)
//   imem_rsp_data_i     fetched instruction word
//   redirect_i          flush and restart request
//   redirect_pc_i       restart PC (bits [1:0] ignored)
//   if_valid_o          if_pc_o/if_instr_o are valid
//   if_ready_i          IF/ID accepts the head instruction
//   if_pc_o, if_instr_o head of the instruction buffer (0 when empty)
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter int                  FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o
);

    localparam int AW = $clog2(FIFO_DEPTH);  // pointer width
    localparam int CW = AW + 1;              // counter width, holds 0..FIFO_DEPTH
    localparam int SW = CW + 1;              // width of the credit sum

    // Fetch PC and counters
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [CW-1:0]          r_out_cnt;
    logic [CW-1:0]          r_drop_cnt;

    // Request-PC tag FIFO: its occupancy always equals r_out_cnt
    logic [PC_WIDTH-1:0]    r_tag_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_tag_wptr;
    logic [AW-1:0]          r_tag_rptr;

    // Instruction buffer {pc, instr}
    logic [PC_WIDTH-1:0]    r_buf_pc_mem    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] r_buf_instr_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_buf_wptr;
    logic [AW-1:0]          r_buf_rptr;
    logic [CW-1:0]          r_buf_cnt;

    logic                   w_buf_empty;
    logic                   w_if_valid;
    logic                   w_pop;
    logic [SW-1:0]          w_credit_used;
    logic                   w_req_valid;
    logic                   w_accept;
    logic                   w_rsp_drop;
    logic                   w_rsp_keep;
    logic                   w_buf_wr;

    assign w_buf_empty = (r_buf_cnt == '0);
    assign w_if_valid  = !rst && !redirect_i && !w_buf_empty;
    assign w_pop       = w_if_valid && if_ready_i;

    // Every request in flight (kept or dropped) and every buffered word holds
    // one credit. A pop in the same cycle frees its slot early, which is what
    // allows one instruction per cycle with a single-cycle memory.
    assign w_credit_used = SW'(r_out_cnt) + SW'(r_drop_cnt) + SW'(r_buf_cnt) - SW'(w_pop);
    assign w_req_valid   = !rst && !redirect_i && (w_credit_used < SW'(FIFO_DEPTH));
    assign w_accept      = w_req_valid && imem_req_ready_i;

    // Dropped responses always precede kept ones (memory is in order), so a
    // non-zero drop count means the current response belongs to the old path.
    assign w_rsp_drop = imem_rsp_valid_i && (r_drop_cnt != '0);
    assign w_rsp_keep = imem_rsp_valid_i && (r_drop_cnt == '0);
    assign w_buf_wr   = !rst && !redirect_i && w_rsp_keep;

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_fetch_pc;
    assign if_valid_o       = w_if_valid;

    // The buffer is a tiny register file; the head is read directly so a
    // response is visible on the very next cycle. Zero while empty.
    assign if_pc_o    = w_buf_empty ? '0 : r_buf_pc_mem[r_buf_rptr];
    assign if_instr_o = w_buf_empty ? '0 : r_buf_instr_mem[r_buf_rptr];

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_buf_wptr <= '0;
            r_buf_rptr <= '0;
            r_buf_cnt  <= '0;
        end else if (redirect_i) begin
            // Every kept request still in flight becomes a dropped one; a
            // response landing this cycle is consumed from whichever pool it
            // belongs to, so the total shrinks by one either way.
            r_drop_cnt <= r_drop_cnt + r_out_cnt - CW'(imem_rsp_valid_i);
            r_out_cnt  <= '0;
            r_fetch_pc <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
            r_buf_wptr <= '0;
            r_buf_rptr <= '0;
            r_buf_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
                r_tag_wptr <= r_tag_wptr + AW'(1);
            end
            if (w_rsp_keep) begin
                r_tag_rptr <= r_tag_rptr + AW'(1);
                r_buf_wptr <= r_buf_wptr + AW'(1);
            end
            if (w_pop) begin
                r_buf_rptr <= r_buf_rptr + AW'(1);
            end
            r_out_cnt  <= r_out_cnt + CW'(w_accept) - CW'(w_rsp_keep);
            r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
            r_buf_cnt  <= r_buf_cnt + CW'(w_buf_wr) - CW'(w_pop);

            // The credit rule makes a write into a full buffer impossible.
            assert (!(w_buf_wr && ((r_buf_cnt - CW'(w_pop)) == CW'(FIFO_DEPTH))));
        end
    end

    // Storage arrays (no reset needed: contents are qualified by the counters)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wptr] <= r_fetch_pc;
        end
        // A response is never for a request accepted in the same cycle, so
        // the tag read here never collides with the tag write above.
        if (w_buf_wr) begin
            r_buf_pc_mem[r_buf_wptr]    <= r_tag_mem[r_tag_rptr];
            r_buf_instr_mem[r_buf_wptr] <= imem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    always #5 clk = ~clk;

    ifu_fetch #(
        .PC_WIDTH   (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .if_valid_o      (if_valid_o),
        .if_ready_i      (if_ready_i),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o)
    );

    // In-order memory model: accepted requests wait in a queue until due.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t memq[$];

    typedef struct {
        logic [31:0] rpc;       // redirect_pc_i applied
        logic [31:0] exp_addr;  // expected restart address / first PC out
    } vec_t;
    vec_t vecs[5];

    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    int n_cmp = 0, n_bad = 0, n_pop = 0, n_acc = 0;
    int mark = 0, first_pop_cyc = -1;
    logic [31:0] first_pop_pc = '0, first_acc_addr = '0;
    logic        first_acc_seen = 1'b0;
    logic [31:0] exp_req_pc = RST_PC, exp_out_pc = RST_PC;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        obs_req_valid, obs_if_valid, obs_rsp;
    logic [31:0] obs_req_addr, obs_if_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_mark();
        mark           = cyc;
        first_pop_cyc  = -1;
        first_acc_seen = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then update the reference model with what the rising edge will commit.
    task automatic cycle(input logic redir, input logic [31:0] rpc,
                         input logic rdy_mem, input logic rdy_if);
        logic  rsp;
        mreq_t m;
        int    lat;
        @(negedge clk);
        rst              = 1'b0;
        redirect_i       = redir;
        redirect_pc_i    = rpc;
        imem_req_ready_i = rdy_mem;
        if_ready_i       = rdy_if;
        rsp              = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? mem_word(memq[0].addr) : $urandom;
        #1;
        obs_req_valid = imem_req_valid_o;
        obs_req_addr  = imem_req_addr_o;
        obs_if_valid  = if_valid_o;
        obs_if_pc     = if_pc_o;
        obs_rsp       = rsp;
        if (redir) begin
            chk("redir_req_valid", 32'(imem_req_valid_o), 32'd0);
            chk("redir_if_valid", 32'(if_valid_o), 32'd0);
        end
        if (hold_pend && !redir) begin
            chk("hold_valid", 32'(imem_req_valid_o), 32'd1);
            chk("hold_addr", imem_req_addr_o, hold_addr);
        end
        hold_pend = imem_req_valid_o && !rdy_mem;
        hold_addr = imem_req_addr_o;
        if (imem_req_valid_o && rdy_mem) begin
            chk("req_addr", imem_req_addr_o, exp_req_pc);
            lat    = $urandom_range(lat_max, lat_min);
            m.addr = imem_req_addr_o;
            m.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = m.due;
            memq.push_back(m);
            chk("credit_le_depth", 32'(memq.size() <= 2), 32'd1);
            if (!first_acc_seen) begin
                first_acc_seen = 1'b1;
                first_acc_addr = imem_req_addr_o;
            end
            exp_req_pc += 32'd4;
            n_acc++;
        end
        if (if_valid_o && rdy_if) begin
            chk("if_pc", if_pc_o, exp_out_pc);
            chk("if_instr", if_instr_o, mem_word(exp_out_pc));
            if (first_pop_cyc < 0) begin
                first_pop_cyc = cyc;
                first_pop_pc  = if_pc_o;
            end
            exp_out_pc += 32'd4;
            n_pop++;
        end
        if (rsp) void'(memq.pop_front());
        if (redir) begin
            exp_req_pc = rpc & 32'hFFFF_FFFC;
            exp_out_pc = rpc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst              = 1'b1;
        redirect_i       = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b1;
        if_ready_i       = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_req_addr", imem_req_addr_o, RST_PC);
        chk("rst_if_valid", 32'(if_valid_o), 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        chk("rst_if_instr", if_instr_o, 32'd0);
        memq.delete();
        last_due   = cyc;
        exp_req_pc = RST_PC;
        exp_out_pc = RST_PC;
        hold_pend  = 1'b0;
        n_acc      = 0;
        n_pop      = 0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    endtask

    initial begin
        int p0;
        vecs[0] = '{32'h8000_0103, 32'h8000_0100};
        vecs[1] = '{32'h0000_0001, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFA, 32'hFFFF_FFF8};
        vecs[3] = '{32'h1234_5677, 32'h1234_5674};
        vecs[4] = '{32'h0000_0200, 32'h0000_0200};

        // Reset, then stream with a 1-cycle memory
        do_reset(2);
        lat_min = 1; lat_max = 1;
        set_mark();
        stream(12);
        chk("stream_first_cycle", 32'(first_pop_cyc), 32'(mark + 2));
        chk("stream_first_pc", first_pop_pc, RST_PC);
        chk("stream_throughput", 32'(n_pop), 32'd10);
        $display("stream: first pc %h at +%0d, %0d delivered", first_pop_pc, first_pop_cyc - mark, n_pop);

        // Reset in the middle of streaming
        do_reset(1);

        // Output backpressure for 10 cycles
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
        chk("bp_if_valid", 32'(obs_if_valid), 32'd1);
        chk("bp_if_pc", obs_if_pc, RST_PC);
        chk("bp_req_valid", 32'(obs_req_valid), 32'd0);
        chk("bp_accepted", 32'(n_acc), 32'd2);
        chk("bp_no_pop", 32'(n_pop), 32'd0);
        stream(6);
        chk("bp_release_pops", 32'(n_pop), 32'd6);
        $display("backpressure: %0d accepted while held, %0d delivered after release", n_acc, n_pop);

        // Memory stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'd0, 1'b0, 1'b1);
            chk("stall_req_valid", 32'(obs_req_valid), 32'd1);
        end
        p0 = n_pop;
        stream(6);
        chk("stall_resume", 32'(n_pop - p0 >= 4), 32'd1);
        $display("stall: resumed, %0d delivered in 6 cycles", n_pop - p0);

        // Table of redirect targets with a 1-cycle memory
        foreach (vecs[k]) begin
            set_mark();
            cycle(1'b1, vecs[k].rpc, 1'b1, 1'b1);
            cycle(1'b0, 32'd0, 1'b1, 1'b1);
            chk("vec_req_valid", 32'(obs_req_valid), 32'd1);
            chk("vec_req_addr", obs_req_addr, vecs[k].exp_addr);
            stream(5);
            chk("vec_first_cycle", 32'(first_pop_cyc), 32'(mark + 3));
            chk("vec_first_pc", first_pop_pc, vecs[k].exp_addr);
            $display("redirect %h: restart %h, first pc %h at R+%0d",
                     vecs[k].rpc, obs_req_addr, first_pop_pc, first_pop_cyc - mark);
        end

        // Redirect with requests in flight, 3-cycle memory
        lat_min = 3; lat_max = 3;
        stream(8);
        set_mark();
        cycle(1'b1, 32'h8000_0103, 1'b1, 1'b1);
        stream(12);
        chk("inflight_first_req", first_acc_addr, 32'h8000_0100);
        chk("inflight_first_pc", first_pop_pc, 32'h8000_0100);
        $display("redirect in flight: first req %h, first pc %h", first_acc_addr, first_pop_pc);

        // Redirect coinciding with a response while if_ready_i=1
        lat_min = 2; lat_max = 2;
        stream(6);
        for (int i = 0; i < 10; i++) begin
            if (memq.size() > 0 && memq[0].due <= cyc) break;
            cycle(1'b0, 32'd0, 1'b1, 1'b1);
        end
        p0 = n_pop;
        set_mark();
        cycle(1'b1, 32'h8000_0400, 1'b1, 1'b1);
        chk("coinc_no_pop", 32'(n_pop), 32'(p0));
        stream(12);
        chk("coinc_first_pc", first_pop_pc, 32'h8000_0400);
        chk("coinc_progress", 32'(n_pop - p0 >= 4), 32'd1);
        $display("redirect with response (rsp=%0b): first pc %h", obs_rsp, first_pop_pc);

        // Back-to-back redirects, then wrap past the top of the address space
        stream(6);
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        set_mark();
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        stream(12);
        chk("b2b_first_req", first_acc_addr, 32'h0000_0200);
        chk("b2b_first_pc", first_pop_pc, 32'h0000_0200);
        set_mark();
        cycle(1'b1, 32'hFFFF_FFF5, 1'b1, 1'b1);
        p0 = n_pop;
        stream(12);
        chk("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF4);
        chk("wrap_progress", 32'(n_pop - p0 >= 4), 32'd1);
        $display("back-to-back: first pc %h; wrap run delivered %0d", first_pop_pc, n_pop - p0);

        // Randomized traffic against the reference model
        lat_min = 1; lat_max = 4;
        p0 = n_pop;
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic [31:0] pc;
            r  = ($urandom_range(99, 0) < 4);
            pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                             : $urandom;
            cycle(r, pc, ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7));
        end
        chk("random_progress", 32'(n_pop - p0 >= 300), 32'd1);
        $display("random: %0d instructions delivered", n_pop - p0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
